// File: rtl/dispatch_scheduler_pkg.sv
// Shared definitions for the dispatch scheduler: class codes, tag width,
// scheduler states and small class-decoding helpers.
package dispatch_scheduler_pkg;

  localparam int ROB_WIDTH = 4;
  localparam logic [ROB_WIDTH-1:0] EMPTY_TAG = '0;

  localparam int CLS_W = 3;

  // LUI and AUIPC share one code: both are upper-immediate RS ops.
  localparam logic [CLS_W-1:0] CLS_ALU     = 3'd0;
  localparam logic [CLS_W-1:0] CLS_LUI     = 3'd1;
  localparam logic [CLS_W-1:0] CLS_AUIPC   = 3'd1;
  localparam logic [CLS_W-1:0] CLS_BRANCH  = 3'd2;
  localparam logic [CLS_W-1:0] CLS_JAL     = 3'd3;
  localparam logic [CLS_W-1:0] CLS_JALR    = 3'd4;
  localparam logic [CLS_W-1:0] CLS_LOAD    = 3'd5;
  localparam logic [CLS_W-1:0] CLS_STORE   = 3'd6;
  localparam logic [CLS_W-1:0] CLS_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    SCH_RUN         = 2'd0,
    SCH_SERIAL_WAIT = 2'd1,
    SCH_FLUSH       = 2'd2
  } sch_state_e;

  function automatic logic cls_is_lsb(input logic [CLS_W-1:0] c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

  function automatic logic cls_is_illegal(input logic [CLS_W-1:0] c);
    return c == CLS_ILLEGAL;
  endfunction

  function automatic logic cls_is_jalr(input logic [CLS_W-1:0] c);
    return c == CLS_JALR;
  endfunction

endpackage

// File: rtl/dispatch_scheduler_fifo.sv
// sched_fifo: synchronous FIFO of {class, payload} entries with
// push, pop, clear, full and empty; pointers wrap modulo DEPTH.
module sched_fifo #(
  parameter int W     = 131,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_scheduler.sv
// Dispatch scheduler: buffers decoded instructions and issues one per cycle
// to RS/LSB with a ROB tag. Optional counters: define SCHED_PERF_EN.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int TAG_W     = ROB_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 dec_valid,
  input  logic [CLS_W-1:0]     dec_class,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  output logic                 dec_ready,
  input  logic                 rob_full,
  input  logic                 rob_empty,
  input  logic [TAG_W-1:0]     rob_tail_tag,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 iss_rob_valid,
  output logic                 iss_rs_valid,
  output logic                 iss_lsb_valid,
  output logic [TAG_W-1:0]     iss_tag,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic                 err_illegal,
  output logic                 busy,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_issued
);

  localparam int EW = CLS_W + PAYLOAD_W;

  sch_state_e           state;
  sch_state_e           state_n;
  logic [EW-1:0]        head;
  logic [CLS_W-1:0]     head_cls;
  logic [PAYLOAD_W-1:0] head_pl;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 flush;
  logic                 can;
  logic                 to_lsb;
  logic                 unit_free;
  logic                 go;
  logic                 drop;

  assign head_cls  = head[PAYLOAD_W +: CLS_W];
  assign head_pl   = head[PAYLOAD_W-1:0];
  assign to_lsb    = cls_is_lsb(head_cls);
  assign unit_free = to_lsb ? !lsb_full : !rs_full;

  assign dec_ready = !rst && !buf_full && !clr && rdy
                   && (state != SCH_FLUSH);
  assign flush     = clr && rdy;
  assign can       = rdy && !clr && (state == SCH_RUN) && !buf_empty;
  assign drop      = can && cls_is_illegal(head_cls);
  assign go        = can && !cls_is_illegal(head_cls)
                   && !rob_full && unit_free;
  assign busy      = (state != SCH_RUN) || !buf_empty;

  sched_fifo #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dec_valid && dec_ready),
    .pop   (go || drop),
    .clear (flush),
    .din   ({dec_class, dec_payload}),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_comb begin
    state_n = state;
    if (rdy) begin
      if (clr) begin
        state_n = SCH_FLUSH;
      end else begin
        unique case (state)
          SCH_RUN:
            if (go && cls_is_jalr(head_cls)) state_n = SCH_SERIAL_WAIT;
          SCH_SERIAL_WAIT:
            if (rob_empty) state_n = SCH_RUN;
          SCH_FLUSH:
            state_n = SCH_RUN;
          default:
            state_n = SCH_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SCH_RUN;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_rob_valid <= 1'b0;
      iss_rs_valid  <= 1'b0;
      iss_lsb_valid <= 1'b0;
      err_illegal   <= 1'b0;
      iss_tag       <= '0;
      iss_payload   <= '0;
    end else begin
      iss_rob_valid <= go;
      iss_rs_valid  <= go && !to_lsb;
      iss_lsb_valid <= go && to_lsb;
      err_illegal   <= drop;
      iss_tag       <= go ? rob_tail_tag : '0;
      iss_payload   <= go ? head_pl : '0;
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] issued_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (rdy && !buf_empty && !go) stall_q <= stall_q + 32'd1;
      if (iss_rob_valid) issued_q <= issued_q + 32'd1;
    end
  end

  assign perf_stall  = stall_q;
  assign perf_issued = issued_q;
`else
  assign perf_stall  = 32'd0;
  assign perf_issued = 32'd0;
`endif

endmodule
